// File: rtl/snn_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// snn_seq_ctrl_if
// Bundle of every non-clock signal around the SNN sequencer: UART RX byte
// hand-off, input-unit RAM port, snn_core start/done, UART TX request and the
// status/debug outputs.
//
// Handshakes:
//   rx_rdy/clr_rx_rdy : rx_rdy is a level "byte available"; the sequencer
//                       consumes the byte by pulsing clr_rx_rdy for one cycle
//                       in the cycle it samples rx_data.
//   core_start/done   : one-cycle start pulse, one-cycle done pulse with
//                       core_digit valid in the done cycle.
//   tx_start/tx_done  : one-cycle request with tx_data stable, one-cycle done.
//
// master = sequencer side, slave = environment (UART, RAM, core).
// -----------------------------------------------------------------------------
interface snn_seq_ctrl_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic [9:0] ram_addr;
  logic       ram_data;
  logic       ram_we;
  logic [9:0] core_addr;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [3:0] digit;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    input  rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
    output clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
           tx_start, tx_data, digit, busy, state_dbg
  );

  modport slave (
    output rx_rdy, rx_data, core_addr, core_done, core_digit, tx_done,
    input  clr_rx_rdy, ram_addr, ram_data, ram_we, core_start,
           tx_start, tx_data, digit, busy, state_dbg
  );
endinterface

// File: rtl/snn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// snn_seq_ctrl
// Top-level sequencer for the SNN digit classifier. Receives a binary image as
// NUM_BITS/8 UART bytes, unpacks each byte LSB first into the 1-bit input-unit
// RAM, starts snn_core, lends the RAM address port to the core while it runs,
// then sends the recognised digit back over UART as ASCII.
//
// Ports:
//   clk    : system clock, posedge
//   rst_n  : asynchronous active-low reset
//   bus    : snn_seq_ctrl_if.master (RX byte, RAM port, core start/done,
//            TX request, digit/busy status, state_dbg = FSM state encoding)
// -----------------------------------------------------------------------------
module snn_seq_ctrl #(
  parameter int         NUM_BITS   = 784,
  parameter logic [7:0] ASCII_BASE = 8'h30
) (
  input logic            clk,
  input logic            rst_n,
  snn_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    LOAD_WAIT = 3'd0,
    UNPACK    = 3'd1,
    START     = 3'd2,
    RUN       = 3'd3,
    SEND      = 3'd4,
    WAIT_TX   = 3'd5
  } state_t;

  localparam logic [9:0] LAST_ADDR = 10'(NUM_BITS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] wptr;
  logic [7:0] shreg;
  logic [2:0] bcnt;
  logic [3:0] digit_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Events that do not belong to the current state are
  // simply not looked at, so a pending RX byte waits for LOAD_WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_WAIT: if (bus.rx_rdy) state_nxt = UNPACK;
      UNPACK: begin
        if (bcnt == 3'd7) begin
          state_nxt = (wptr == LAST_ADDR) ? START : LOAD_WAIT;
        end
      end
      START:     state_nxt = RUN;
      RUN:       if (bus.core_done) state_nxt = SEND;
      SEND:      state_nxt = WAIT_TX;
      WAIT_TX:   if (bus.tx_done) state_nxt = LOAD_WAIT;
      default:   state_nxt = LOAD_WAIT;
    endcase
  end

  // Datapath registers: byte shifter, write pointer, bit counter, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      shreg   <= '0;
      bcnt    <= '0;
      digit_q <= '0;
    end else begin
      case (state)
        LOAD_WAIT: begin
          if (bus.rx_rdy) begin
            shreg <= bus.rx_data;
            bcnt  <= '0;
          end
        end
        UNPACK: begin
          shreg <= {1'b0, shreg[7:1]};
          wptr  <= wptr + 10'd1;
          bcnt  <= bcnt + 3'd1;
        end
        RUN: begin
          if (bus.core_done) digit_q <= bus.core_digit;
        end
        WAIT_TX: begin
          // Rewind so the next image is written from address 0.
          if (bus.tx_done) wptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Output logic. The RAM address is owned by the core only during RUN.
  always_comb begin
    bus.clr_rx_rdy = 1'b0;
    bus.ram_addr   = wptr;
    bus.ram_data   = 1'b0;
    bus.ram_we     = 1'b0;
    bus.core_start = 1'b0;
    bus.tx_start   = 1'b0;
    bus.busy       = 1'b1;
    case (state)
      LOAD_WAIT: begin
        bus.busy       = 1'b0;
        bus.clr_rx_rdy = bus.rx_rdy;
      end
      UNPACK: begin
        bus.ram_we   = 1'b1;
        bus.ram_data = shreg[0];
      end
      START:   bus.core_start = 1'b1;
      RUN:     bus.ram_addr   = bus.core_addr;
      SEND:    bus.tx_start   = 1'b1;
      default: ;
    endcase
  end

  assign bus.tx_data   = ASCII_BASE + {4'h0, digit_q};
  assign bus.digit     = digit_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
module tb_snn_seq_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_seq_ctrl_if bus_if ();

  snn_seq_ctrl #(.NUM_BITS(784), .ASCII_BASE(8'h30)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [9:0] core_addr;
    logic       core_done;
    logic [3:0] core_digit;
    logic       tx_done;
    logic       e_clr;
    logic       e_we;
    logic [9:0] e_addr;
    logic       e_data;
    logic       e_cs;
    logic       e_txs;
    logic       e_busy;
    logic [7:0] e_txd;
  } vec_t;

  function automatic vec_t mk(
    input logic rx, input logic [7:0] rxd, input logic [9:0] ca,
    input logic cd, input logic [3:0] cdig, input logic txd_done,
    input logic clr, input logic we, input logic [9:0] addr, input logic dat,
    input logic cs, input logic txs, input logic busy, input logic [7:0] txd);
    vec_t v;
    v.rx_rdy = rx;   v.rx_data = rxd;   v.core_addr = ca;
    v.core_done = cd; v.core_digit = cdig; v.tx_done = txd_done;
    v.e_clr = clr;   v.e_we = we;       v.e_addr = addr;  v.e_data = dat;
    v.e_cs = cs;     v.e_txs = txs;     v.e_busy = busy;  v.e_txd = txd;
    return v;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [10:0] exp_q[$];
  int wr_cnt = 0;
  int start_cnt = 0;
  int start_cyc = -1;
  int wr783_cyc = -100;
  int wptr_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every RAM write must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (bus_if.ram_we === 1'b1) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data %0b, expected no write",
                     bus_if.ram_addr, bus_if.ram_data);
          end else begin
            check("ram_write", {21'b0, bus_if.ram_addr, bus_if.ram_data},
                  {21'b0, exp_q.pop_front()});
          end
          wr_cnt++;
          if (bus_if.ram_addr == 10'd783) wr783_cyc = cyc;
        end
        if (bus_if.core_start === 1'b1) begin
          start_cnt++;
          start_cyc = cyc;
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    bus_if.rx_rdy     = 1'b0;
    bus_if.rx_data    = 8'h00;
    bus_if.core_addr  = 10'h000;
    bus_if.core_done  = 1'b0;
    bus_if.core_digit = 4'h0;
    bus_if.tx_done    = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    bus_if.rx_rdy     = v.rx_rdy;
    bus_if.rx_data    = v.rx_data;
    bus_if.core_addr  = v.core_addr;
    bus_if.core_done  = v.core_done;
    bus_if.core_digit = v.core_digit;
    bus_if.tx_done    = v.tx_done;
    #1;
    check($sformatf("%s[%0d].clr_rx_rdy", tag, idx), 32'(bus_if.clr_rx_rdy), 32'(v.e_clr));
    check($sformatf("%s[%0d].ram_we", tag, idx),     32'(bus_if.ram_we),     32'(v.e_we));
    check($sformatf("%s[%0d].ram_addr", tag, idx),   32'(bus_if.ram_addr),   32'(v.e_addr));
    check($sformatf("%s[%0d].ram_data", tag, idx),   32'(bus_if.ram_data),   32'(v.e_data));
    check($sformatf("%s[%0d].core_start", tag, idx), 32'(bus_if.core_start), 32'(v.e_cs));
    check($sformatf("%s[%0d].tx_start", tag, idx),   32'(bus_if.tx_start),   32'(v.e_txs));
    check($sformatf("%s[%0d].busy", tag, idx),       32'(bus_if.busy),       32'(v.e_busy));
    check($sformatf("%s[%0d].tx_data", tag, idx),    32'(bus_if.tx_data),    32'(v.e_txd));
    if (v.e_we) exp_q.push_back({v.e_addr, v.e_data});
  endtask

  // Present a byte, wait (bounded) for it to be consumed, then idle.
  task automatic send_byte(input logic [7:0] b, input int idle);
    int n;
    for (int k = 0; k < 8; k++) exp_q.push_back({10'(wptr_model + k), b[k]});
    wptr_model += 8;
    @(negedge clk);
    bus_if.rx_rdy  = 1'b1;
    bus_if.rx_data = b;
    #1;
    n = 0;
    while (bus_if.clr_rx_rdy !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rx_consume", 32'(bus_if.clr_rx_rdy), 32'd1);
    @(negedge clk);
    bus_if.rx_rdy = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    wptr_model = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".clr_rx_rdy"}, 32'(bus_if.clr_rx_rdy), 32'd0);
    check({tag, ".ram_we"},     32'(bus_if.ram_we),     32'd0);
    check({tag, ".ram_addr"},   32'(bus_if.ram_addr),   32'd0);
    check({tag, ".ram_data"},   32'(bus_if.ram_data),   32'd0);
    check({tag, ".core_start"}, 32'(bus_if.core_start), 32'd0);
    check({tag, ".tx_start"},   32'(bus_if.tx_start),   32'd0);
    check({tag, ".busy"},       32'(bus_if.busy),       32'd0);
    check({tag, ".tx_data"},    32'(bus_if.tx_data),    32'h30);
    check({tag, ".digit"},      32'(bus_if.digit),      32'd0);
    check({tag, ".state"},      32'(bus_if.state_dbg),  32'd0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- test
  initial begin
    vec_t tbl_a5[$];
    vec_t tbl_run[$];
    logic [7:0] pa5;
    logic [7:0] p0f;
    int start_base;

    pa5 = 8'hA5;
    p0f = 8'h0F;

    // A5 at image start: capture cycle, 8 writes LSB first, back to idle.
    tbl_a5.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  1, 0, 10'd0, 0, 0, 0, 0, 8'h30));
    for (int k = 0; k < 8; k++)
      tbl_a5.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 10'(k), pa5[k], 0, 0, 1, 8'h30));
    tbl_a5.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 10'd8, 0, 0, 0, 0, 8'h30));

    // In RUN after a full image (wptr = 784 = 10'h310).
    tbl_run.push_back(mk(0, 8'h00, 10'h123, 0, 0, 1,  0, 0, 10'h123, 0, 0, 0, 1, 8'h30)); // tx_done ignored
    tbl_run.push_back(mk(1, 8'h0F, 10'h123, 0, 0, 0,  0, 0, 10'h123, 0, 0, 0, 1, 8'h30)); // rx held pending
    tbl_run.push_back(mk(1, 8'h0F, 10'h0AA, 1, 7, 0,  0, 0, 10'h0AA, 0, 0, 0, 1, 8'h30)); // core_done
    tbl_run.push_back(mk(1, 8'h0F, 10'h0AA, 0, 0, 0,  0, 0, 10'h310, 0, 0, 1, 1, 8'h37)); // SEND
    tbl_run.push_back(mk(1, 8'h0F, 10'h0AA, 0, 0, 0,  0, 0, 10'h310, 0, 0, 0, 1, 8'h37)); // WAIT_TX
    tbl_run.push_back(mk(1, 8'h0F, 10'h0AA, 0, 0, 1,  0, 0, 10'h310, 0, 0, 0, 1, 8'h37)); // tx_done wins
    tbl_run.push_back(mk(1, 8'h0F, 10'h000, 0, 0, 0,  1, 0, 10'h000, 0, 0, 0, 0, 8'h37)); // consume 0F
    for (int k = 0; k < 8; k++)
      tbl_run.push_back(mk(0, 0, 0, 0, 0, 0,  0, 1, 10'(k), p0f[k], 0, 0, 1, 8'h37));
    tbl_run.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 10'd8, 0, 0, 0, 0, 8'h37));
    tbl_run.push_back(mk(0, 0, 0, 1, 3, 0,  0, 0, 10'd8, 0, 0, 0, 0, 8'h37)); // core_done ignored
    tbl_run.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 10'd8, 0, 0, 0, 0, 8'h37));
    tbl_run.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 10'd8, 0, 0, 0, 0, 8'h37));

    // Reset state
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single A5 byte
    foreach (tbl_a5[i]) apply_vec(tbl_a5[i], "a5", i);
    check("a5.state", 32'(bus_if.state_dbg), 32'd0);

    // Full image of 0xFF
    do_reset();
    wr_cnt = 0;
    start_cnt = 0;
    for (int i = 0; i < 98; i++) send_byte(8'hFF, 28);
    check("img.write_count", 32'(wr_cnt), 32'd784);
    check("img.start_count", 32'(start_cnt), 32'd1);
    check("img.start_latency", 32'(start_cyc - wr783_cyc), 32'd1);
    check("img.queue_left", 32'(exp_q.size()), 32'd0);
    check("img.state_run", 32'(bus_if.state_dbg), 32'd3);

    // RUN mux, result, TX, pending byte, event filtering
    foreach (tbl_run[i]) apply_vec(tbl_run[i], "run", i);
    check("run.digit_held", 32'(bus_if.digit), 32'd7);

    // Reset during UNPACK of byte 50
    do_reset();
    start_cnt = 0;
    for (int i = 0; i < 49; i++) send_byte(8'(i * 29 + 5), 20);
    send_byte(8'h3C, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    wptr_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(mk(0, 0, 0, 1, 5, 0,  0, 0, 10'd0, 0, 0, 0, 0, 8'h30), "postrst", 0);
    apply_vec(mk(0, 0, 0, 0, 0, 0,  0, 0, 10'd0, 0, 0, 0, 0, 8'h30), "postrst", 1);
    start_base = start_cnt;
    wr_cnt = 0;
    for (int i = 0; i < 97; i++) send_byte(8'(i * 53 + 17), 12);
    check("reimg.no_early_start", 32'(start_cnt), 32'(start_base));
    send_byte(8'hC3, 12);
    check("reimg.start_count", 32'(start_cnt), 32'(start_base + 1));
    check("reimg.write_count", 32'(wr_cnt), 32'd784);

    // Close out with digit 9
    apply_vec(mk(0, 0, 10'h055, 1, 9, 0,  0, 0, 10'h055, 0, 0, 0, 1, 8'h30), "fin", 0);
    apply_vec(mk(0, 0, 10'h000, 0, 0, 0,  0, 0, 10'h310, 0, 0, 1, 1, 8'h39), "fin", 1);
    apply_vec(mk(0, 0, 10'h000, 0, 0, 1,  0, 0, 10'h310, 0, 0, 0, 1, 8'h39), "fin", 2);
    apply_vec(mk(0, 0, 10'h000, 0, 0, 0,  0, 0, 10'h000, 0, 0, 0, 0, 8'h39), "fin", 3);
    check("fin.digit", 32'(bus_if.digit), 32'd9);
    check("fin.queue_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
